// File: rtl/bit_pixel_pkg.sv
// Shared types and geometry for the bit-pixel writer/reader pair.
// Both ends derive buffer layout from the same localparams so they agree on addressing.
package bit_pixel_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_SOF,
        ST_WRITING,
        ST_PUBLISH
    } writer_state_t;

    typedef enum logic [1:0] {
        REG_LEFT,
        REG_CENTERLEFT,
        REG_CENTERRIGHT,
        REG_RIGHT
    } region_t;

    localparam int unsigned THIRD_WIDTH   = 240;
    localparam int unsigned THIRD_HEIGHT  = 480;
    localparam int unsigned BYTES_PER_ROW = THIRD_WIDTH / 8;
    localparam int unsigned THIRD_READS   = THIRD_WIDTH * THIRD_HEIGHT / 8;
    localparam int unsigned ADDR_W        = 15;

    function automatic int unsigned bytes_per_row(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs a stream of 1-bit pixels into bytes, leftmost pixel in bit 0.
// i_clear restarts packing; when it coincides with i_valid that pixel becomes bit 0.
module bit_packer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_valid,
    input  logic       i_bit,
    output logic [7:0] o_byte,
    output logic       o_byte_done
);

    logic [7:0] r_shift;
    logic [7:0] w_shift_d;
    logic [7:0] r_byte;
    logic [7:0] w_byte_d;
    logic [7:0] w_base;
    logic [2:0] r_pos;
    logic [2:0] w_pos_d;
    logic [2:0] w_pos;
    logic       r_done;
    logic       w_done_d;

    always_comb begin
        w_base    = i_clear ? 8'h00 : r_shift;
        w_pos     = i_clear ? 3'd0 : r_pos;
        w_shift_d = w_base;
        w_pos_d   = w_pos;
        w_byte_d  = r_byte;
        w_done_d  = 1'b0;
        if (i_valid) begin
            w_base[w_pos] = i_bit;
            if (w_pos == 3'd7) begin
                w_byte_d  = w_base;
                w_done_d  = 1'b1;
                w_shift_d = 8'h00;
                w_pos_d   = 3'd0;
            end else begin
                w_shift_d = w_base;
                w_pos_d   = w_pos + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= 8'h00;
            r_byte  <= 8'h00;
            r_pos   <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_shift <= w_shift_d;
            r_byte  <= w_byte_d;
            r_pos   <= w_pos_d;
            r_done  <= w_done_d;
        end
    end

    assign o_byte      = r_byte;
    assign o_byte_done = r_done;

endmodule

// File: rtl/bit_pixel_writer.sv
// Producer side of the double-buffered bit-pixel RAMs: packs a raster of 1-bit pixels
// into per-region bytes and publishes each completed frame by bumping image_number.
module bit_pixel_writer
    import bit_pixel_pkg::*;
#(
    parameter int unsigned third_width  = THIRD_WIDTH,
    parameter int unsigned third_height = THIRD_HEIGHT
) (
    input  logic        pclk,
    input  logic        pclk_reset_n,
    input  logic        pixel_bit,
    input  logic        pixel_sof,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [3:0]  image_number,
    output logic        frame_error,
    output logic [15:0] wr_address_left,
    output logic [15:0] wr_address_centerleft,
    output logic [15:0] wr_address_centerright,
    output logic [15:0] wr_address_right,
    output logic [7:0]  wr_data_left,
    output logic [7:0]  wr_data_centerleft,
    output logic [7:0]  wr_data_centerright,
    output logic [7:0]  wr_data_right,
    output logic        wr_en_left,
    output logic        wr_en_centerleft,
    output logic        wr_en_centerright,
    output logic        wr_en_right
);

    localparam int unsigned BytesPerRow = bytes_per_row(third_width);
    localparam int unsigned SubW        = $clog2(third_width);
    localparam int unsigned RowW        = (third_height > 1) ? $clog2(third_height) : 1;

    writer_state_t    r_state;
    writer_state_t    w_state_d;
    region_t          r_region;
    region_t          w_region_d;
    region_t          r_wr_region;
    region_t          w_wr_region_d;
    logic [SubW-1:0]  r_subcol;
    logic [SubW-1:0]  w_subcol_d;
    logic [RowW-1:0]  r_row;
    logic [RowW-1:0]  w_row_d;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] w_row_base_d;
    logic [15:0]      r_wr_address;
    logic [15:0]      w_wr_address_d;
    logic             r_buf_index;
    logic             w_buf_index_d;
    logic [3:0]       r_image_number;
    logic [3:0]       w_image_number_d;
    logic             r_frame_error;
    logic             w_frame_error_d;

    logic             w_accept;
    logic             w_sof_take;
    logic             w_pack_valid;
    logic             w_end_subcol;
    logic             w_last;
    logic             w_byte_end;
    logic             w_origin;
    logic [7:0]       w_byte;
    logic             w_byte_done;

    assign pixel_ready  = (r_state != ST_PUBLISH);
    assign w_accept     = pixel_valid && pixel_ready;
    assign w_sof_take   = w_accept && pixel_sof;
    assign w_pack_valid = w_accept && (pixel_sof || (r_state == ST_WRITING));
    assign w_end_subcol = (r_subcol == SubW'(third_width - 1));
    assign w_last       = w_end_subcol && (r_region == REG_RIGHT)
                          && (r_row == RowW'(third_height - 1));
    assign w_byte_end   = (r_state == ST_WRITING) && w_accept && !pixel_sof
                          && (r_subcol[2:0] == 3'd7);
    assign w_origin     = (r_row == '0) && (r_region == REG_LEFT) && (r_subcol == '0);

    always_comb begin
        w_state_d        = r_state;
        w_region_d       = r_region;
        w_subcol_d       = r_subcol;
        w_row_d          = r_row;
        w_row_base_d     = r_row_base;
        w_wr_address_d   = r_wr_address;
        w_wr_region_d    = r_wr_region;
        w_buf_index_d    = r_buf_index;
        w_image_number_d = r_image_number;
        w_frame_error_d  = 1'b0;

        // Any accepted sof lands on col 0 / row 0, so the counters step past it.
        if (w_sof_take) begin
            w_state_d    = ST_WRITING;
            w_subcol_d   = SubW'(1);
            w_region_d   = REG_LEFT;
            w_row_d      = '0;
            w_row_base_d = '0;
        end

        case (r_state)
            ST_WRITING: begin
                if (w_sof_take) begin
                    w_frame_error_d = !w_origin;
                end else if (w_accept) begin
                    if (w_byte_end) begin
                        w_wr_address_d = {r_buf_index,
                                          r_row_base + ADDR_W'(r_subcol >> 3)};
                        w_wr_region_d  = r_region;
                    end
                    if (w_last) begin
                        w_state_d    = ST_PUBLISH;
                        w_subcol_d   = '0;
                        w_region_d   = REG_LEFT;
                        w_row_d      = '0;
                        w_row_base_d = '0;
                    end else if (w_end_subcol) begin
                        w_subcol_d = '0;
                        w_region_d = region_t'(r_region + 2'd1);
                        if (r_region == REG_RIGHT) begin
                            w_row_d      = r_row + RowW'(1);
                            w_row_base_d = r_row_base + ADDR_W'(BytesPerRow);
                        end
                    end else begin
                        w_subcol_d = r_subcol + SubW'(1);
                    end
                end
            end
            ST_PUBLISH: begin
                w_state_d        = ST_WAIT_SOF;
                w_image_number_d = r_image_number + 4'd1;
                w_buf_index_d    = !r_buf_index;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            r_state        <= ST_WAIT_SOF;
            r_region       <= REG_LEFT;
            r_subcol       <= '0;
            r_row          <= '0;
            r_row_base     <= '0;
            r_wr_address   <= '0;
            r_wr_region    <= REG_LEFT;
            r_buf_index    <= 1'b0;
            r_image_number <= 4'd0;
            r_frame_error  <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_region       <= w_region_d;
            r_subcol       <= w_subcol_d;
            r_row          <= w_row_d;
            r_row_base     <= w_row_base_d;
            r_wr_address   <= w_wr_address_d;
            r_wr_region    <= w_wr_region_d;
            r_buf_index    <= w_buf_index_d;
            r_image_number <= w_image_number_d;
            r_frame_error  <= w_frame_error_d;
        end
    end

    bit_packer u_packer (
        .i_clk       (pclk),
        .i_rst_n     (pclk_reset_n),
        .i_clear     (w_sof_take),
        .i_valid     (w_pack_valid),
        .i_bit       (pixel_bit),
        .o_byte      (w_byte),
        .o_byte_done (w_byte_done)
    );

    // Address and data buses are shared; only the latched region's strobe fires.
    assign wr_en_left        = w_byte_done && (r_wr_region == REG_LEFT);
    assign wr_en_centerleft  = w_byte_done && (r_wr_region == REG_CENTERLEFT);
    assign wr_en_centerright = w_byte_done && (r_wr_region == REG_CENTERRIGHT);
    assign wr_en_right       = w_byte_done && (r_wr_region == REG_RIGHT);

    assign wr_address_left        = r_wr_address;
    assign wr_address_centerleft  = r_wr_address;
    assign wr_address_centerright = r_wr_address;
    assign wr_address_right       = r_wr_address;
    assign wr_data_left           = w_byte;
    assign wr_data_centerleft     = w_byte;
    assign wr_data_centerright    = w_byte;
    assign wr_data_right          = w_byte;

    assign image_number = r_image_number;
    assign frame_error  = r_frame_error;

endmodule
